// File: rtl/fe_mul_seq.sv
// Sequential GF(2^255-19) multiplier: 64-cycle radix-2^32 schoolbook multiply
// through one 32x32 multiplier, then 2^256==38 and 2^255==19 folds and an optional subtract of p.
module fe_mul_seq #(
  parameter bit FULL_REDUCE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [319:0] mult_op_a,
  input  logic [319:0] mult_op_b,
  input  logic         mult_valid,
  output logic [319:0] mult_res,
  output logic         mult_done,
  output logic         busy
);
  localparam logic [255:0] P = {1'b0, {250{1'b1}}, 5'b01101};

  typedef enum logic [2:0] {IDLE, MUL, FOLD1, FOLD2, FINAL, DONE} state_t;
  state_t state, state_nxt;

  logic [255:0] a_q, b_q;
  logic [511:0] acc;
  logic [262:0] red;
  logic [2:0]   i_q, j_q;
  logic [31:0]  a_limb, b_limb;
  logic [63:0]  prod;
  logic [8:0]   sh;
  logic [511:0] term;
  logic [262:0] fold1;
  logic [255:0] fold2, fin;
  logic         unused_hi;

  // Upper 64 bits of each operand bus carry no data.
  assign unused_hi = ^{mult_op_a[319:256], mult_op_b[319:256]};

  assign a_limb = a_q[{i_q, 5'b0} +: 32];
  assign b_limb = b_q[{j_q, 5'b0} +: 32];
  assign prod   = {32'b0, a_limb} * {32'b0, b_limb};
  assign sh     = {({1'b0, i_q} + {1'b0, j_q}), 5'b0};
  assign term   = {448'b0, prod} << sh;
  assign fold1  = {7'b0, acc[255:0]} + {7'b0, acc[511:256]} * 263'd38;
  assign fold2  = {1'b0, red[254:0]} + {248'b0, red[262:255]} * 256'd19;
  // fold2 < 2p, so a single conditional subtract lands in [0,p-1].
  assign fin    = (red[255:0] >= P) ? red[255:0] - P : red[255:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mult_done = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:  if (mult_valid) state_nxt = MUL;
      MUL: begin
        busy = 1'b1;
        if (i_q == 3'd7 && j_q == 3'd7) state_nxt = FOLD1;
      end
      FOLD1: begin
        busy      = 1'b1;
        state_nxt = FOLD2;
      end
      FOLD2: begin
        busy      = 1'b1;
        state_nxt = FULL_REDUCE ? FINAL : DONE;
      end
      FINAL: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        mult_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      red      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      mult_res <= '0;
    end else begin
      case (state)
        IDLE: if (mult_valid) begin
          a_q <= mult_op_a[255:0];
          b_q <= mult_op_b[255:0];
          acc <= '0;
          i_q <= '0;
          j_q <= '0;
        end
        MUL: begin
          acc <= acc + term;
          j_q <= j_q + 3'd1;
          if (j_q == 3'd7) i_q <= i_q + 3'd1;
        end
        FOLD1: red <= fold1;
        FOLD2: begin
          if (FULL_REDUCE) red <= {7'b0, fold2};
          else             mult_res <= {64'b0, fold2};
        end
        FINAL: mult_res <= {64'b0, fin};
        default: ;
      endcase
    end
  end
endmodule
